// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed big-endian byte stream into the fetch unit's
// flat MSB-first instruction image and holds the CPU in reset until the load completes.
module imem_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic [0:32*MEM_WORDS-1]   mem_image,
    output logic                      cpu_reset,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               words_loaded
);
    localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;

    state_t      state, state_nx;
    logic [15:0] len;
    logic [15:0] len_rx;
    logic [1:0]  cnt;
    logic [23:0] assembly;
    logic        acc;
    logic        last_word;

    // Handshake and status outputs are pure decodes of the state register.
    assign in_ready  = state == LEN_HI || state == LEN_LO || state == DATA;
    assign busy      = in_ready;
    assign done      = state == DONE;
    assign error     = state == ERROR;
    assign cpu_reset = state != DONE;

    always_comb begin
        acc       = in_valid && in_ready;
        len_rx    = {len[15:8], in_data};
        last_word = cnt == 2'd3 && words_loaded + 16'd1 == len;
        state_nx  = state;
        case (state)
            LEN_HI:  state_nx = acc ? LEN_LO : state;
            LEN_LO:  state_nx = !acc ? state : (len_rx != 16'd0 && len_rx <= MAX_LEN) ? DATA : ERROR;
            DATA:    state_nx = acc && last_word ? DONE : state;
            default: state_nx = state;
        endcase
        if (start)
            state_nx = LEN_HI;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // start takes priority over any byte offered on the same edge.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            mem_image    <= '0;
            words_loaded <= '0;
            cnt          <= '0;
            assembly     <= '0;
            len          <= '0;
        end else if (acc) begin
            if (state == LEN_HI)
                len[15:8] <= in_data;
            if (state == LEN_LO)
                len[7:0] <= in_data;
            if (state == DATA) begin
                cnt      <= cnt + 2'd1;
                assembly <= {assembly[15:0], in_data};
                if (cnt == 2'd3) begin
                    mem_image[32*words_loaded[AW-1:0] +: 32] <= {assembly, in_data};
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written abort/reset/error sequences
// against a bench-built expected image.
module tb_imem_loader;
    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, cpu_reset, busy, done, error;
    logic [15:0]   words_loaded;
    logic [0:8191] mem_image;
    logic [0:8191] exp_img;
    int            total = 0;
    int            bad = 0;

    imem_loader #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_image(mem_image), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // flags = {in_ready, busy, done, error, cpu_reset}
    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic [4:0]  flags;
        logic [15:0] wl;
    } vec_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       err;
    } len_t;

    localparam logic [4:0] F_IDLE = 5'b00001;
    localparam logic [4:0] F_BUSY = 5'b11001;
    localparam logic [4:0] F_DONE = 5'b00100;
    localparam logic [4:0] F_ERR  = 5'b00011;

    vec_t       v[13];
    len_t       lt[4];
    logic [7:0] s2[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name);
        logic shown;
        total++;
        if (mem_image !== exp_img) begin
            bad++;
            shown = 1'b0;
            for (int i = 0; i < 256; i++)
                if (!shown && mem_image[32*i +: 32] !== exp_img[32*i +: 32]) begin
                    $display("FAIL %s: word %0d got %h want %h", name, i,
                             mem_image[32*i +: 32], exp_img[32*i +: 32]);
                    shown = 1'b1;
                end
        end
    endtask

    function automatic logic [4:0] flags();
        return {in_ready, busy, done, error, cpu_reset};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic sent;
        sent = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        for (int k = 0; k < 20 && !sent; k++) begin
            sent = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL send_byte: in_ready never high for byte %h", b);
        end
    endtask

    initial begin
        v = '{
            '{1'b1, 1'b0, 8'h00, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h00, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h02, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h12, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h34, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h56, F_BUSY, 16'd0},
            '{1'b0, 1'b1, 8'h78, F_BUSY, 16'd1},
            '{1'b0, 1'b0, 8'h00, F_BUSY, 16'd1},
            '{1'b0, 1'b1, 8'h9A, F_BUSY, 16'd1},
            '{1'b0, 1'b1, 8'hBC, F_BUSY, 16'd1},
            '{1'b0, 1'b1, 8'hDE, F_BUSY, 16'd1},
            '{1'b0, 1'b1, 8'hF0, F_DONE, 16'd2},
            '{1'b0, 1'b1, 8'h55, F_DONE, 16'd2}
        };
        lt = '{
            '{8'h00, 8'h00, 1'b1},
            '{8'h01, 8'h01, 1'b1},
            '{8'h00, 8'h01, 1'b0},
            '{8'h01, 8'h00, 1'b0}
        };
        s2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        exp_img = '0;
        repeat (2) tick();
        chk("reset flags", 32'(flags()), 32'(F_IDLE));
        chk("reset words", 32'(words_loaded), 32'd0);
        chk_img("reset image");
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            start = v[i].start;
            in_valid = v[i].valid;
            in_data = v[i].data;
            tick();
            chk($sformatf("vec%0d flags", i), 32'(flags()), 32'(v[i].flags));
            chk($sformatf("vec%0d words", i), 32'(words_loaded), 32'(v[i].wl));
        end
        start = 1'b0;
        in_valid = 1'b0;
        exp_img[0 +: 32] = 32'h12345678;
        exp_img[32 +: 32] = 32'h9ABCDEF0;
        chk_img("two-word image");

        start_load();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = s2[i];
            tick();
            in_valid = 1'b0;
            chk($sformatf("toggle ready %0d", i), 32'(in_ready), i < 9 ? 32'd1 : 32'd0);
            tick();
        end
        chk("toggle flags", 32'(flags()), 32'(F_DONE));
        chk("toggle words", 32'(words_loaded), 32'd2);
        chk_img("toggle image");

        exp_img = '0;
        for (int t = 0; t < 4; t++) begin
            start_load();
            send_byte(lt[t].hi);
            send_byte(lt[t].lo);
            chk($sformatf("len%0d flags", t), 32'(flags()), lt[t].err ? 32'(F_ERR) : 32'(F_BUSY));
            if (lt[t].err) begin
                in_valid = 1'b1;
                in_data = 8'hFF;
                repeat (3) tick();
                in_valid = 1'b0;
                chk($sformatf("len%0d hold", t), 32'(flags()), 32'(F_ERR));
                chk($sformatf("len%0d words", t), 32'(words_loaded), 32'd0);
                chk_img("error image");
            end
        end

        start_load();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'(i));
            exp_img[32*i +: 32] = 32'(i);
        end
        chk("full flags", 32'(flags()), 32'(F_DONE));
        chk("full words", 32'(words_loaded), 32'd256);
        chk("full last word", mem_image[8160 +: 32], 32'h000000FF);
        chk_img("full image");

        start_load();
        exp_img = '0;
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 1; i <= 6; i++)
            send_byte(8'(8'h11 * i));
        chk("pre-abort words", 32'(words_loaded), 32'd1);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("abort flags", 32'(flags()), 32'(F_BUSY));
        chk("abort words", 32'(words_loaded), 32'd0);
        chk_img("abort image");
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        exp_img[0 +: 32] = 32'hAABBCCDD;
        chk("reload flags", 32'(flags()), 32'(F_DONE));
        chk("reload words", 32'(words_loaded), 32'd1);
        chk_img("reload image");

        start_load();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hCC;
        tick();
        reset = 1'b0;
        start = 1'b0;
        exp_img = '0;
        chk("rst+start flags", 32'(flags()), 32'(F_IDLE));
        chk("rst+start words", 32'(words_loaded), 32'd0);
        chk_img("rst+start image");
        in_data = 8'hDD;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("idle ignores flags", 32'(flags()), 32'(F_IDLE));
        chk_img("idle ignores image");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory image read by the fetch stage. The block receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word into a flat MSB-first memory image that feeds the fetch unit's instructionMemory input. It holds the CPU in reset until a complete program has been loaded.

Parameters:
MEM_WORDS, 256, instruction-memory depth in 32-bit words; image width is 32*MEM_WORDS bits (8192 at default).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a new load; restarts from any state
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_image  output  [0:32*MEM_WORDS-1]  instruction image; word i occupies bits 32*i (MSB) through 32*i+31 (LSB)
cpu_reset  output  1  drive to CPU reset; high until load completes
busy  output  1  load in progress
done  output  1  level; program loaded successfully
error  output  1  level; illegal length received
words_loaded  output  16  count of words written in the current load

Behaviour:
- Reset (sync, active-high) values: state IDLE, mem_image all 0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0, in_ready=0, byte counter=0, length register=0.
- Byte transfer: a byte is accepted only on a clock edge where in_valid=1 and in_ready=1. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO and DATA; 0 otherwise.
- States:
  - IDLE: wait for start.
  - LEN_HI: accept the length high byte -> LEN_LO.
  - LEN_LO: accept the length low byte. If the 16-bit length is in 1..MEM_WORDS -> DATA; otherwise -> ERROR.
  - DATA: accept bytes. A 2-bit byte counter shifts each byte into a 32-bit assembly register, first byte = bits 31:24. On the edge accepting the 4th byte, write the full word into mem_image word[words_loaded], increment words_loaded and clear the byte counter. If words_loaded+1 equals length -> DONE.
  - DONE: done=1, busy=0, cpu_reset=0. Hold until start or reset.
  - ERROR: error=1, busy=0, cpu_reset=1. Hold until start or reset.
- start (sampled in any state, including mid-DATA) takes effect on that edge:
  - mem_image cleared to 0; words_loaded, byte counter and assembly register cleared.
  - done=0, error=0, busy=1, cpu_reset=1; next state LEN_HI.
  - Any byte handshaking on the same edge is discarded.
- start and reset asserted together: reset wins.
- busy=1 in LEN_HI, LEN_LO and DATA.
- cpu_reset falls on the same edge that enters DONE. mem_image is stable from that edge onward.
- Unwritten words beyond length remain 0.
- Partial word at an abort (start/reset mid-word) is never written.
- Image writes are full-word only; no read-modify-write; no wrap-around. Addressing cannot exceed MEM_WORDS-1 because length is bounded.
- in_valid while in_ready=0: ignored; the byte is not consumed.
- Latency: one accepted byte per cycle at most. A load takes 2+4*length accepting cycles.

Test Plan:
- Reset then start, stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> mem_image bits 0..31=0x12345678, 32..63=0x9ABCDEF0, rest 0; words_loaded=2; done=1, cpu_reset=0 on the edge of the last byte.
- Same stream with in_valid toggled every other cycle -> identical image; in_ready stays 1 throughout DATA; no byte lost or duplicated.
- Length 00 00, and separately 01 01 (257) -> error=1, cpu_reset=1, in_ready=0; further bytes ignored; mem_image stays 0.
- Length 01 00 (256 words), word i = i -> last word at bits 8160..8191 = 0x000000FF; done=1; words_loaded=256.
- Start asserted after 6 data bytes of a 2-word load -> image cleared, state LEN_HI, words_loaded=0, done=0; a fresh 1-word load of AABBCCDD gives word 0 = 0xAABBCCDD.
- Reset asserted during DATA with start also high -> all outputs at reset values, cpu_reset=1, state IDLE; no words written.
